// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - producer byte handshake plus transmitter launch/pacing signals
interface uart_tx_fifo_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done;

  // slave is the buffer's view; master is the producer/transmitter side
  modport slave (
    input  in_valid, in_data, tx_busy, tx_done,
    output in_ready, tx_start, tx_data
  );

  modport master (
    output in_valid, in_data, tx_busy, tx_done,
    input  in_ready, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO and launch controller feeding a UART transmitter
module uart_tx_fifo #(
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_fifo_if.slave bus,
  output logic [AW:0]   fifo_count,
  output logic          fifo_empty,
  output logic          fifo_full,
  output logic          tx_active,
  output logic [15:0]   bytes_sent
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;

  state_t        state;
  state_t        state_next;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // in_ready depends only on the registered count, never on this cycle's pop
  assign fifo_empty   = (fifo_count == '0);
  assign fifo_full    = (fifo_count == (AW+1)'(DEPTH));
  assign bus.in_ready = !fifo_full;
  assign push         = bus.in_valid && bus.in_ready;
  assign tx_active    = (state != IDLE);

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && !bus.tx_busy) begin
          pop        = 1'b1;
          state_next = LAUNCH;
        end
      end
      LAUNCH:    state_next = WAIT_DONE;
      WAIT_DONE: if (bus.tx_done) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      bus.tx_start <= 1'b0;
      bus.tx_data  <= '0;
      bytes_sent   <= '0;
    end else begin
      state        <= state_next;
      bus.tx_start <= pop;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        bus.tx_data <= mem[rd_ptr];
        rd_ptr      <= rd_ptr + AW'(1);
      end
      if (push && !pop)      fifo_count <= fifo_count + (AW+1)'(1);
      else if (pop && !push) fifo_count <= fifo_count - (AW+1)'(1);
      if (state == WAIT_DONE && bus.tx_done) bytes_sent <= bytes_sent + 16'd1;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo with a behavioural transmitter
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int BAUD  = 4;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  fifo_count;
  logic        fifo_empty;
  logic        fifo_full;
  logic        tx_active;
  logic [15:0] bytes_sent;

  logic        hold_busy = 1'b0;
  logic        m_busy;
  logic        m_done;
  logic        line;
  int          m_tick;
  int          m_bit;
  logic [9:0]  m_frame;

  int          passed = 0;
  int          total  = 0;
  logic [7:0]  launch_q[$];
  logic [7:0]  line_q[$];

  bit          rx_on;
  int          rx_cnt;
  logic [9:0]  rx_bits;
  logic        prev_start = 1'b0;

  uart_tx_fifo_if bus();

  assign bus.tx_busy = m_busy | hold_busy;
  assign bus.tx_done = m_done;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .fifo_count (fifo_count),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .tx_active  (tx_active),
    .bytes_sent (bytes_sent)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // transmitter: busy/done registered, done pulses with busy still high
  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      line   <= 1'b1;
      m_tick <= 0;
      m_bit  <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (bus.tx_start) begin
          m_busy  <= 1'b1;
          m_frame <= {1'b1, bus.tx_data, 1'b0};
          m_bit   <= 0;
          m_tick  <= 0;
          line    <= 1'b0;
        end
      end else if (m_done) begin
        m_busy <= 1'b0;
      end else if (m_tick == BAUD - 1) begin
        m_tick <= 0;
        if (m_bit == 9) m_done <= 1'b1;
        else begin
          m_bit <= m_bit + 1;
          line  <= m_frame[m_bit+1];
        end
      end else begin
        m_tick <= m_tick + 1;
      end
    end
  end

  // serial receiver, samples mid-bit
  initial begin
    rx_on = 0;
    rx_cnt = 0;
    rx_bits = '0;
    forever begin
      @(negedge clk);
      if (reset) rx_on = 0;
      else if (!rx_on) begin
        if (line === 1'b0) begin
          rx_on  = 1;
          rx_cnt = 0;
        end
      end else rx_cnt++;
      if (rx_on && !reset && (rx_cnt % BAUD) == BAUD / 2) begin
        rx_bits[rx_cnt/BAUD] = line;
        if (rx_cnt / BAUD == 9) begin
          rx_on = 0;
          check("start_bit", rx_bits[0], 0);
          check("stop_bit", rx_bits[9], 1);
          if (line_q.size() == 0) check("line_q_underflow", 0, 1);
          else check("line_byte", rx_bits[8:1], line_q.pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset && bus.tx_start) begin
        check("gate_busy", bus.tx_busy, 0);
        check("start_pulse", prev_start, 0);
        if (launch_q.size() == 0) check("launch_q_underflow", 0, 1);
        else check("tx_data", bus.tx_data, launch_q.pop_front());
      end
      prev_start = bus.tx_start;
    end
  end

  task automatic push_byte(input logic [7:0] b, output bit ok);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    ok = bus.in_ready;
    if (ok) begin
      launch_q.push_back(b);
      line_q.push_back(b);
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (bus.tx_done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (bus.tx_done !== 1'b1) check("done_timeout", 0, 1);
  endtask

  task automatic drain(input int target);
    int n = 0;
    while (bytes_sent != 16'(target) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("drain_bytes_sent", bytes_sent, target);
  endtask

  initial begin
    bit ok;
    bit saw_start;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_tx_start", bus.tx_start, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_tx_active", tx_active, 0);
    check("rst_count", fifo_count, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_full", fifo_full, 0);
    check("rst_bytes_sent", bytes_sent, 0);

    push_byte(8'hA5, ok);
    check("single_ok", ok, 1);
    check("single_not_empty", fifo_empty, 0);
    check("single_count", fifo_count, 1);
    @(negedge clk);
    check("single_start", bus.tx_start, 1);
    check("single_data", bus.tx_data, 8'hA5);
    check("single_active", tx_active, 1);
    check("single_empty", fifo_empty, 1);
    @(negedge clk);
    check("single_start_low", bus.tx_start, 0);
    wait_done();
    @(negedge clk);
    check("single_bytes_sent", bytes_sent, 1);
    check("single_idle", tx_active, 0);

    push_byte(8'h11, ok);
    push_byte(8'h22, ok);
    push_byte(8'h33, ok);
    for (int k = 0; k < 2; k++) begin
      wait_done();
      @(negedge clk);
      check("gap_idle", bus.tx_start, 0);
      check("gap_inactive", tx_active, 0);
      @(negedge clk);
      check("gap_launch", bus.tx_start, 1);
    end
    wait_done();
    @(negedge clk);
    check("order_bytes_sent", bytes_sent, 4);

    hold_busy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      push_byte(8'(i), ok);
      check("fill_accept", ok, (i < 16) ? 1 : 0);
    end
    check("fill_full", fifo_full, 1);
    check("fill_in_ready", bus.in_ready, 0);
    check("fill_count", fifo_count, 16);

    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    hold_busy    = 1'b0;
    check("simul_blocked", bus.in_ready, 0);
    @(negedge clk);
    check("simul_pop_count", fifo_count, 15);
    check("simul_ready", bus.in_ready, 1);
    check("simul_launch", bus.tx_start, 1);
    launch_q.push_back(8'h77);
    line_q.push_back(8'h77);
    @(negedge clk);
    check("simul_refill", fifo_count, 16);
    check("simul_full", fifo_full, 1);
    bus.in_valid = 1'b0;
    drain(21);
    check("launch_q_empty", launch_q.size(), 0);
    check("line_q_empty", line_q.size(), 0);

    push_byte(8'hC1, ok);
    push_byte(8'hC2, ok);
    push_byte(8'hC3, ok);
    push_byte(8'hC4, ok);
    repeat (6) @(negedge clk);
    check("mid_active", tx_active, 1);
    check("mid_count", fifo_count, 3);
    reset = 1'b1;
    launch_q.delete();
    line_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_empty", fifo_empty, 1);
    check("mid_rst_active", tx_active, 0);
    check("mid_rst_bytes", bytes_sent, 0);
    check("mid_rst_ready", bus.in_ready, 1);
    saw_start = 0;
    repeat (200) begin
      @(negedge clk);
      if (bus.tx_start) saw_start = 1;
    end
    check("mid_no_start", saw_start, 0);
    check("mid_bytes_after", bytes_sent, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
